// File: rtl/fpu_pkg.sv
// Shared FPU add/sub definitions: default widths, exponent limits and the
// normaliser result flags consumed by the packing stage.
package fpu_pkg;

  localparam int FPU_SIZE_EXP     = 8;
  localparam int FPU_SIZE_MAN     = 23;
  localparam int FPU_EXP_ALL_ONES = (1 << FPU_SIZE_EXP) - 1;
  localparam int FPU_EXP_MAX      = FPU_EXP_ALL_ONES - 1;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic underflow;
  } norm_flags_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module fpu_lzc
  import fpu_pkg::*;
#(
  parameter int WIDTH = FPU_SIZE_MAN + 1,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in,
  output logic [CW-1:0]    cnt
);

  logic found;

  always_comb begin
    cnt   = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in[i]) begin
        cnt   = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_add_normalize.sv
// Post-add normaliser: carry right-shift or cancellation left-shift of the raw
// mantissa sum, two-stage valid/ready pipeline, flush-to-zero, truncation.
module fpu_add_normalize
  import fpu_pkg::*;
#(
  parameter int SIZE_EXP = FPU_SIZE_EXP,
  parameter int SIZE_MAN = FPU_SIZE_MAN
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MAN+1:0] i_man_sum,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_zero,
  output logic                o_overflow,
  output logic                o_underflow
);

  localparam int STAGES   = 2;
  localparam int LZW      = $clog2(SIZE_MAN + 2);
  // Internal exponent width: wide enough for exp+1 and for lzc, so nothing wraps.
  localparam int XW       = ((SIZE_EXP > LZW) ? SIZE_EXP : LZW) + 1;
  localparam int EXP_ONES = (1 << SIZE_EXP) - 1;

  logic [STAGES:1]     vld_pipe;
  logic                s2_adv;

  logic                s1_sign;
  logic [SIZE_EXP-1:0] s1_exp;
  logic [SIZE_MAN+1:0] s1_sum;

  logic                s1_carry;
  logic                s1_zero;
  logic [LZW-1:0]      s1_lzc;
  logic [XW-1:0]       exp_x;
  logic [XW-1:0]       lzc_x;
  logic [XW-1:0]       exp_inc;
  logic [SIZE_MAN:0]   shifted;

  logic [SIZE_EXP-1:0] nx_exp;
  logic [SIZE_MAN-1:0] nx_man;
  norm_flags_t         nx_flags;

  assign s2_adv  = ~vld_pipe[2] | i_ready;
  assign o_ready = ~vld_pipe[1] | s2_adv;
  assign o_valid = vld_pipe[2];

  // Stage 1 analysis on the registered sum
  assign s1_carry = s1_sum[SIZE_MAN+1];
  assign s1_zero  = (s1_sum == '0);

  fpu_lzc #(.WIDTH(SIZE_MAN + 1), .CW(LZW)) u_lzc (
    .in  (s1_sum[SIZE_MAN:0]),
    .cnt (s1_lzc)
  );

  assign exp_x   = XW'(s1_exp);
  assign lzc_x   = XW'(s1_lzc);
  assign exp_inc = exp_x + XW'(1);
  assign shifted = s1_sum[SIZE_MAN:0] << s1_lzc;

  always_comb begin
    nx_exp   = '0;
    nx_man   = '0;
    nx_flags = '0;
    if (s1_zero) begin
      nx_flags.zero = 1'b1;
    end else if (s1_carry && exp_inc >= XW'(EXP_ONES)) begin
      nx_exp            = '1;
      nx_flags.overflow = 1'b1;
    end else if (s1_carry) begin
      nx_exp = SIZE_EXP'(exp_inc);
      nx_man = s1_sum[SIZE_MAN:1];
    end else if (lzc_x >= exp_x) begin
      nx_flags.underflow = 1'b1;
    end else begin
      nx_exp = SIZE_EXP'(exp_x - lzc_x);
      nx_man = shifted[SIZE_MAN-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_sum   <= '0;
    end else begin
      if (o_ready) begin
        vld_pipe[1] <= i_valid;
        if (i_valid) begin
          s1_sign <= i_sign;
          s1_exp  <= i_exp;
          s1_sum  <= i_man_sum;
        end
      end
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Output registers only move on a stage-2 load of a real beat, so a stalled
  // beat stays stable on the outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_man       <= '0;
      o_zero      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (s2_adv && vld_pipe[1]) begin
      o_sign      <= s1_sign;
      o_exp       <= nx_exp;
      o_man       <= nx_man;
      o_zero      <= nx_flags.zero;
      o_overflow  <= nx_flags.overflow;
      o_underflow <= nx_flags.underflow;
    end
  end

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Scoreboard bench for fpu_add_normalize (SIZE_EXP=8, SIZE_MAN=23).
module tb_fpu_add_normalize;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic        zero;
    logic        ovf;
    logic        unf;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [24:0] i_man_sum;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [22:0] o_man;
  logic        o_zero;
  logic        o_overflow;
  logic        o_underflow;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb_q[$];
  logic  rnd_done;

  fpu_add_normalize #(.SIZE_EXP(8), .SIZE_MAN(23)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_man_sum   (i_man_sum),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sign      (o_sign),
    .o_exp       (o_exp),
    .o_man       (o_man),
    .o_zero      (o_zero),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(logic s, logic [7:0] e, logic [22:0] m,
                               logic z, logic ov, logic un);
    beat_t b;
    b = '{sign: s, exp: e, man: m, zero: z, ovf: ov, unf: un};
    return b;
  endfunction

  // Reference normaliser written straight from the behaviour description.
  function automatic beat_t model(logic s, logic [7:0] e, logic [24:0] sum);
    beat_t       r;
    int          lz;
    logic [24:0] t;
    r = '0;
    r.sign = s;
    if (sum == 25'd0) r.zero = 1'b1;
    else if (sum[24]) begin
      if (e == 8'hFE) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        r.exp = e + 8'd1;
        r.man = sum[23:1];
      end
    end else begin
      lz = 0;
      while (!sum[23-lz]) lz++;
      if (lz >= int'(e)) r.unf = 1'b1;
      else begin
        r.exp = e - 8'(lz);
        t     = sum << lz;
        r.man = t[22:0];
      end
    end
    return r;
  endfunction

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] sum,
                      input beat_t eb);
    logic acc;
    int   n;
    n       = 0;
    acc     = 1'b0;
    i_valid = 1'b1;
    i_sign  = s;
    i_exp   = e;
    i_man_sum = sum;
    forever begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (acc) sb_q.push_back(eb);
    i_valid = 1'b0;
  endtask

  // Output monitor: scoreboard compare on transfer, stability compare on stall.
  logic [35:0] held;
  logic        held_ok = 1'b0;
  always @(negedge i_clk) begin
    logic [35:0] cur;
    cur = {o_valid, o_sign, o_exp, o_man, o_zero, o_overflow, o_underflow};
    if (i_rst) held_ok = 1'b0;
    else begin
      if (held_ok) chk("hold", 64'(cur), 64'(held));
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
        else chk("beat", 64'(cur[34:0]), 64'(sb_q.pop_front()));
      end
      held_ok = o_valid && !i_ready;
      held    = cur;
    end
  end

  initial begin
    logic [24:0] sum;
    logic [7:0]  e;
    logic        s;
    int          n;

    i_rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_man_sum = '0;
    i_ready = 1'b1; rnd_done = 1'b0;
    #12;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_ready", 64'(o_ready), 64'd1);
    chk("rst_outputs", 64'({o_sign, o_exp, o_man, o_zero, o_overflow, o_underflow}), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Directed vectors with hand-derived results
    send(1'b0, 8'h80, 25'h0800000, mk(1'b0, 8'h80, 23'h0,      1'b0, 1'b0, 1'b0));
    send(1'b0, 8'h80, 25'h1000001, mk(1'b0, 8'h81, 23'h0,      1'b0, 1'b0, 1'b0));
    send(1'b0, 8'hFE, 25'h1000001, mk(1'b0, 8'hFF, 23'h0,      1'b0, 1'b1, 1'b0));
    send(1'b0, 8'h80, 25'h0000001, mk(1'b0, 8'h69, 23'h0,      1'b0, 1'b0, 1'b0));
    send(1'b0, 8'h17, 25'h0000001, mk(1'b0, 8'h00, 23'h0,      1'b0, 1'b0, 1'b1));
    send(1'b1, 8'h40, 25'h0000000, mk(1'b1, 8'h00, 23'h0,      1'b1, 1'b0, 1'b0));
    send(1'b1, 8'h10, 25'h0400003, mk(1'b1, 8'h0F, 23'h000006, 1'b0, 1'b0, 1'b0));
    send(1'b0, 8'h10, 25'h1800003, mk(1'b0, 8'h11, 23'h400001, 1'b0, 1'b0, 1'b0));
    send(1'b1, 8'h01, 25'h0400000, mk(1'b1, 8'h00, 23'h0,      1'b0, 1'b0, 1'b1));
    repeat (4) @(posedge i_clk);
    #1;

    // Back-pressure: three beats against a 4-cycle stall
    i_ready = 1'b0;
    fork
      begin
        send(1'b0, 8'h90, 25'h0ABCDEF, model(1'b0, 8'h90, 25'h0ABCDEF));
        send(1'b1, 8'h91, 25'h1234567, model(1'b1, 8'h91, 25'h1234567));
        send(1'b0, 8'h92, 25'h0000F00, model(1'b0, 8'h92, 25'h0000F00));
      end
      begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("stall_o_ready", 64'(o_ready), 64'd0);
        chk("stall_o_valid", 64'(o_valid), 64'd1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
      end
    join
    repeat (4) @(posedge i_clk);
    #1;

    // Reset with both stages full: in-flight beats are discarded
    i_ready = 1'b0;
    send(1'b0, 8'h50, 25'h0F00000, model(1'b0, 8'h50, 25'h0F00000));
    send(1'b1, 8'h51, 25'h0F00001, model(1'b1, 8'h51, 25'h0F00001));
    #2;
    chk("full_o_valid", 64'(o_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("async_rst_o_valid", 64'(o_valid), 64'd0);
    sb_q.delete();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_ready = 1'b1;
    chk("post_rst_o_ready", 64'(o_ready), 64'd1);
    repeat (6) @(posedge i_clk);
    #1;

    // Random beats under random back-pressure
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          s   = 1'($urandom);
          e   = 8'($urandom_range(1, 254));
          sum = 25'($urandom) >> $urandom_range(0, 24);
          if (k % 10 == 3) sum = 25'd0;
          if (k % 10 == 7) begin
            e   = 8'hFE;
            sum = sum | 25'h1000000;
          end
          send(s, e, sum, model(s, e, sum));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
